// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and defaults for the gshare branch predictor.
//   GSHARE_GHSR_WIDTH  : default global-history length (PHT has 2**W entries)
//   GSHARE_BTB_ENTRIES : default number of direct-mapped BTB lines
//   ctr2_t / WEAK_NT   : 2-bit saturating direction counter and its reset value
//   btb_entry_t        : one BTB line as seen by the lookup path
package gshare_branch_predictor_pkg;

  localparam int GSHARE_GHSR_WIDTH  = 8;
  localparam int GSHARE_BTB_ENTRIES = 16;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t WEAK_NT = 2'b01;

  // The tag field is sized for the smallest legal BTB (2 lines -> 30-bit tag).
  // Larger BTBs zero-extend their narrower tag into it.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage

// File: rtl/gshare_branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
//   cur   : current counter value
//   taken : resolved outcome; moves the counter toward 3 (taken) or 0
//   nxt   : updated counter value, clamped at 0 and 3
module sat_counter2
  import gshare_branch_predictor_pkg::*;
(
  input  ctr2_t cur,
  input  logic  taken,
  output ctr2_t nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// IF-stage gshare direction predictor with a direct-mapped BTB.
// Lookup is combinational on fetch_pc; training, BTB fill and history repair
// come from the EX resolution interface and take effect on the next edge.
//   clk, reset              : clock, asynchronous active-high reset
//   fetch_valid, fetch_pc   : fetch request (halfword-aligned PC)
//   pred_taken/target/ghsr  : prediction and history snapshot for this fetch
//   io_branch_*             : EX resolution (outcome, target, mispredict, PC)
//   io_GHSR_restore         : pred_ghsr snapshot that travelled with the branch
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int GHSR_W      = GSHARE_GHSR_WIDTH,   // >= 2
  parameter int BTB_ENTRIES = GSHARE_BTB_ENTRIES   // power of two, >= 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [GHSR_W-1:0] pred_ghsr,
  input  logic              io_branch_valid,
  input  logic              io_branch_taken,
  input  logic [31:0]       io_branch_addr,
  input  logic [31:0]       io_branch_target_addr,
  input  logic              io_branch_is_mispred,
  input  logic [31:0]       io_branch_instr_pc,
  input  logic [GHSR_W-1:0] io_GHSR_restore
);

  localparam int PHT_N = 1 << GHSR_W;
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 31 - IDX_W;

  ctr2_t             pht        [PHT_N];
  logic              btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
  logic [31:0]       btb_target [BTB_ENTRIES];
  logic [GHSR_W-1:0] ghsr;

  // io_branch_addr feeds the PC mux outside this block; bit 0 of a
  // halfword-aligned PC carries no information.
  logic unused_bits;
  assign unused_bits = ^{io_branch_addr, fetch_pc[0], io_branch_instr_pc[0]};

  // ---- lookup (combinational, reads pre-update state) ----
  logic [GHSR_W-1:0] pht_idx;
  logic [IDX_W-1:0]  btb_idx;
  logic [TAG_W-1:0]  fetch_tag;
  btb_entry_t        rd_entry;
  logic              hit;

  assign pht_idx   = fetch_pc[GHSR_W:1] ^ ghsr;
  assign btb_idx   = fetch_pc[IDX_W:1];
  assign fetch_tag = fetch_pc[31:IDX_W+1];

  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = btb_valid[btb_idx];
    rd_entry.tag    = 30'(btb_tag[btb_idx]);
    rd_entry.target = btb_target[btb_idx];
  end

  assign hit         = rd_entry.valid && (rd_entry.tag == 30'(fetch_tag));
  assign pred_taken  = hit && pht[pht_idx][1];
  assign pred_target = hit ? rd_entry.target : 32'h0;
  assign pred_ghsr   = ghsr;

  // ---- training (state updates on the next edge) ----
  logic [GHSR_W-1:0] tr_pht_idx;
  logic [IDX_W-1:0]  tr_btb_idx;
  ctr2_t             tr_ctr_next;
  logic              btb_write;

  assign tr_pht_idx = io_branch_instr_pc[GHSR_W:1] ^ io_GHSR_restore;
  assign tr_btb_idx = io_branch_instr_pc[IDX_W:1];
  assign btb_write  = io_branch_valid && io_branch_taken;

  sat_counter2 u_sat (
    .cur   (pht[tr_pht_idx]),
    .taken (io_branch_taken),
    .nxt   (tr_ctr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= WEAK_NT;
    end else if (io_branch_valid) begin
      pht[tr_pht_idx] <= tr_ctr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_write) begin
      btb_valid[tr_btb_idx] <= 1'b1;
    end
  end

  // Tag/target are qualified by btb_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (btb_write) begin
      btb_tag[tr_btb_idx]    <= io_branch_instr_pc[31:IDX_W+1];
      btb_target[tr_btb_idx] <= io_branch_target_addr;
    end
  end

  // Repair wins over the speculative shift: the same-cycle fetch is flushed.
  // Fetches that miss the BTB are not known branches and leave history alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghsr <= '0;
    end else if (io_branch_valid && io_branch_is_mispred) begin
      ghsr <= {io_GHSR_restore[GHSR_W-2:0], io_branch_taken};
    end else if (fetch_valid && hit) begin
      ghsr <= {ghsr[GHSR_W-2:0], pred_taken};
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_ghsr;
  logic        io_branch_valid;
  logic        io_branch_taken;
  logic [31:0] io_branch_addr;
  logic [31:0] io_branch_target_addr;
  logic        io_branch_is_mispred;
  logic [31:0] io_branch_instr_pc;
  logic [7:0]  io_GHSR_restore;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [7:0]  ghsr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor #(.GHSR_W(8), .BTB_ENTRIES(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .fetch_valid           (fetch_valid),
    .fetch_pc              (fetch_pc),
    .pred_taken            (pred_taken),
    .pred_target           (pred_target),
    .pred_ghsr             (pred_ghsr),
    .io_branch_valid       (io_branch_valid),
    .io_branch_taken       (io_branch_taken),
    .io_branch_addr        (io_branch_addr),
    .io_branch_target_addr (io_branch_target_addr),
    .io_branch_is_mispred  (io_branch_is_mispred),
    .io_branch_instr_pc    (io_branch_instr_pc),
    .io_GHSR_restore       (io_GHSR_restore)
  );

  // Monitor: each presented fetch is checked against the next queued expectation.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch: pc=%h has no expected entry", fetch_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (pred_taken !== e.taken || pred_target !== e.target || pred_ghsr !== e.ghsr) begin
          errors++;
          $display("FAIL %s: got taken=%b target=%h ghsr=%h, expected taken=%b target=%h ghsr=%h",
                   e.name, pred_taken, pred_target, pred_ghsr, e.taken, e.target, e.ghsr);
        end
      end
    end
  end

  // One cycle of stimulus: optional fetch (with its expected prediction) and
  // optional resolution; inputs drop back to idle after the edge.
  task automatic step(input string name,
                      input logic fv, input logic [31:0] pc,
                      input logic et, input logic [31:0] etgt, input logic [7:0] eg,
                      input logic bv, input logic bt, input logic [31:0] btgt,
                      input logic mp, input logic [31:0] ipc, input logic [7:0] rs);
    exp_t e;
    fetch_valid           = fv;
    fetch_pc              = pc;
    io_branch_valid       = bv;
    io_branch_taken       = bt;
    io_branch_target_addr = btgt;
    io_branch_addr        = bt ? btgt : ipc + 32'd4;
    io_branch_is_mispred  = mp;
    io_branch_instr_pc    = ipc;
    io_GHSR_restore       = rs;
    if (fv) begin
      e.taken = et; e.target = etgt; e.ghsr = eg; e.name = name;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    fetch_valid     = 1'b0;
    io_branch_valid = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [31:0] pc,
                       input logic et, input logic [31:0] etgt, input logic [7:0] eg);
    step(name, 1'b1, pc, et, etgt, eg, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
  endtask

  task automatic resolve(input logic bt, input logic [31:0] btgt, input logic mp,
                         input logic [31:0] ipc, input logic [7:0] rs);
    step("none", 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b1, bt, btgt, mp, ipc, rs);
  endtask

  initial begin
    reset = 1'b1;
    fetch_valid = 1'b0; fetch_pc = '0;
    io_branch_valid = 1'b0; io_branch_taken = 1'b0; io_branch_addr = '0;
    io_branch_target_addr = '0; io_branch_is_mispred = 1'b0;
    io_branch_instr_pc = '0; io_GHSR_restore = '0;
    @(posedge clk);
    #1;

    fetch("reset_state", 32'h100, 1'b0, 32'h0, 8'h00);
    reset = 1'b0;
    fetch("miss_no_shift", 32'h100, 1'b0, 32'h0, 8'h00);
    // Fill BTB and train PHT[0x80] to 2'b10; miss this cycle (read-old).
    step("fill_read_old", 1'b1, 32'h100, 1'b0, 32'h0, 8'h00,
         1'b1, 1'b1, 32'h180, 1'b1, 32'h100, 8'h00);
    // GHSR repaired to 0x01 -> PHT[0x81] still weak not-taken, BTB hits.
    fetch("repair_ghsr_01", 32'h100, 1'b0, 32'h180, 8'h01);
    resolve(1'b0, 32'h0, 1'b1, 32'h200, 8'h00);                 // GHSR -> 0
    fetch("taken_after_train", 32'h100, 1'b1, 32'h180, 8'h00);  // GHSR -> 0x01
    fetch("spec_shift_taken", 32'h100, 1'b0, 32'h180, 8'h01);   // GHSR -> 0x02

    // Saturate PHT[0x80] at 3, then one not-taken (with repair to GHSR 0).
    repeat (4) resolve(1'b1, 32'h180, 1'b0, 32'h100, 8'h00);
    resolve(1'b0, 32'h0, 1'b1, 32'h100, 8'h00);
    fetch("sat3_then_dec", 32'h100, 1'b1, 32'h180, 8'h00);      // GHSR -> 0x01
    resolve(1'b0, 32'h0, 1'b1, 32'h100, 8'h00);                 // ctr 1, GHSR 0
    fetch("dec_to_weak_nt", 32'h100, 1'b0, 32'h180, 8'h00);     // GHSR stays 0
    resolve(1'b1, 32'h180, 1'b0, 32'h100, 8'h00);               // ctr 2

    // Repair beats a same-cycle speculative shift.
    step("repair_priority_fetch", 1'b1, 32'h100, 1'b1, 32'h180, 8'h00,
         1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 8'hA5);
    fetch("repair_a5", 32'h100, 1'b0, 32'h180, 8'h4A);          // GHSR -> 0x94
    resolve(1'b0, 32'h0, 1'b1, 32'h400, 8'h00);                 // GHSR -> 0

    // Same-cycle update and lookup of the same entries.
    step("read_old_target", 1'b1, 32'h100, 1'b1, 32'h180, 8'h00,
         1'b1, 1'b1, 32'h1C0, 1'b0, 32'h100, 8'h00);            // ctr 3, GHSR 0x01
    step("read_old_ctr", 1'b1, 32'h100, 1'b0, 32'h1C0, 8'h01,
         1'b1, 1'b1, 32'h1C0, 1'b0, 32'h100, 8'h01);            // PHT[0x81]=2, GHSR 0x02
    resolve(1'b1, 32'h1C0, 1'b1, 32'h100, 8'h00);               // GHSR -> 0x01
    fetch("new_ctr_visible", 32'h100, 1'b1, 32'h1C0, 8'h01);    // GHSR -> 0x03

    // Resolution fields are ignored when io_branch_valid is low.
    step("ignore_invalid_io", 1'b1, 32'h100, 1'b0, 32'h1C0, 8'h03,
         1'b0, 1'b1, 32'hDEAD_BEE0, 1'b1, 32'h100, 8'hFF);      // GHSR -> 0x06
    fetch("after_invalid_io", 32'h100, 1'b0, 32'h1C0, 8'h06);   // GHSR -> 0x0C

    // Alias at index 0 overwrites the 0x100 line.
    resolve(1'b1, 32'h200, 1'b0, 32'h120, 8'h00);
    fetch("alias_evicts", 32'h100, 1'b0, 32'h0, 8'h0C);
    fetch("alias_hits", 32'h120, 1'b0, 32'h200, 8'h0C);         // GHSR -> 0x18

    // Asynchronous reset in mid-stream, with a resolution pending.
    fetch_pc = 32'h120; fetch_valid = 1'b1;
    io_branch_valid = 1'b1; io_branch_taken = 1'b1; io_branch_is_mispred = 1'b1;
    io_branch_instr_pc = 32'h100; io_branch_target_addr = 32'h180; io_GHSR_restore = 8'h00;
    #1 reset = 1'b1;
    begin
      exp_t e;
      e.taken = 1'b0; e.target = 32'h0; e.ghsr = 8'h00; e.name = "mid_reset";
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    fetch_valid = 1'b0; io_branch_valid = 1'b0;
    reset = 1'b0;
    fetch("post_reset_no_hit", 32'h120, 1'b0, 32'h0, 8'h00);
    // Install 0x100 training a different counter; PHT[0x80] must read weak NT.
    resolve(1'b1, 32'h180, 1'b0, 32'h100, 8'h01);
    fetch("post_reset_ctr_weak", 32'h100, 1'b0, 32'h180, 8'h00);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- IF-stage receiving end of the IF/EX branch-resolution interface.
- Predicts direction and target for each fetched PC using a gshare pattern history table (PHT) and a small direct-mapped BTB.
- Keeps a speculative global history shift register (GHSR).
- Trains the PHT and BTB from EX resolutions, and repairs the GHSR from the EX-supplied snapshot on mispredict.

Parameters:
- GHSR_W, default GSHARE_GHSR_WIDTH (8): history length; PHT has 2**GHSR_W entries of 2-bit counters.
- BTB_ENTRIES, default 16, power of two: number of direct-mapped BTB lines.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  IF advances this cycle with fetch_pc.
- fetch_pc  in  32  PC being fetched; halfword aligned, compressed ISA.
- pred_taken  out  1  predicted taken (BTB hit and PHT counter MSB set).
- pred_target  out  32  BTB target; meaningful only when pred_taken.
- pred_ghsr  out  GHSR_W  GHSR before this fetch's shift; carried down the pipeline and returned by EX as io_GHSR_restore.
- io_branch_valid  in  1  EX resolved a branch/jump this cycle.
- io_branch_taken  in  1  actual outcome.
- io_branch_addr  in  32  corrected next PC. Not used internally; it belongs to the PC mux.
- io_branch_target_addr  in  32  computed taken target.
- io_branch_is_mispred  in  1  direction or target wrong, including BTB miss on a taken branch.
- io_branch_instr_pc  in  32  PC of the resolved instruction.
- io_GHSR_restore  in  GHSR_W  pred_ghsr snapshot that travelled with that instruction.

Behaviour:
- Reset (async):
  - All PHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - GHSR = 0.
  - Outputs settle to pred_taken=0, pred_ghsr=0. pred_target is don't-care but must be driven (0 when no hit).
- Lookup (combinational, same cycle as fetch_pc):
  - pht_idx = fetch_pc[GHSR_W:1] XOR GHSR.
  - btb_idx = fetch_pc[log2(BTB_ENTRIES):1].
  - tag = fetch_pc[31:log2(BTB_ENTRIES)+1].
  - hit = valid[btb_idx] and tag match.
  - pred_taken = hit and pht[pht_idx][1].
  - pred_target = hit ? btb_target[btb_idx] : 0.
  - pred_ghsr = GHSR.
- Speculative history (next edge):
  - If fetch_valid and hit: GHSR <= {GHSR[GHSR_W-2:0], pred_taken}.
  - If fetch_valid and no hit: GHSR unchanged (not known as a branch).
- Repair (next edge):
  - If io_branch_valid and io_branch_is_mispred: GHSR <= {io_GHSR_restore[GHSR_W-2:0], io_branch_taken}.
  - Repair has priority over a same-cycle speculative shift; that fetch is being flushed.
- PHT training (next edge, on io_branch_valid):
  - Index = io_branch_instr_pc[GHSR_W:1] XOR io_GHSR_restore.
  - Counter saturates: increment toward 3 if taken, decrement toward 0 if not taken. No wrap past 0 or 3.
- BTB training (next edge):
  - On io_branch_valid and io_branch_taken: write valid=1, tag and target=io_branch_target_addr at io_branch_instr_pc's index. This overwrites any alias.
  - Not-taken resolutions leave the BTB untouched.
- Same-cycle lookup and update of the same PHT/BTB entry: lookup returns the pre-update value (read-old); the new value is visible from the next cycle.
- io_branch_valid=0: all io_* inputs are ignored.
- Reset asserted mid-operation: all state is cleared immediately; no update is lost or deferred across reset.
- Latency: prediction 0 cycles; training and repair take effect 1 cycle after resolution.

Decomposition:
- Shared package common: GSHARE_GHSR_WIDTH, BTB_ENTRIES default, 2-bit counter typedef with WEAK_NT=2'b01 constant, BTB entry struct {valid, tag, target}.
- One natural sub-module: sat_counter2 (pure function or tiny combinational module giving next counter value from current value and taken).
- PHT and BTB are flop arrays inside the top module.

Test Plan:
- Reset then fetch_pc=0x100 with fetch_valid=1 -> pred_taken=0, pred_ghsr=0; GHSR stays 0 (BTB miss).
- Resolve taken branch instr_pc=0x100, target 0x180, restore=0, mispred=1 -> next cycle GHSR=0x01, BTB hit at 0x100 with target 0x180, PHT[0x80] = 2'b10.
- Fetch 0x100 again with GHSR=0 after the counter reaches 2'b10 -> pred_taken=1, pred_target=0x180; next cycle GHSR=0x01.
- Resolve the same branch taken 4 times, then not-taken once -> counter saturates at 3, then reads 2; prediction still taken.
- Same cycle: fetch_valid with hit predicted taken, plus mispred with restore=0xA5, taken=0 -> GHSR=0x4A; the speculative shift is discarded.
- Resolution and fetch of the same PC in the same cycle -> lookup shows the old counter/BTB value; the next cycle shows the updated values. Assert reset mid-stream -> all counters read 2'b01 and no hits.
